// File: rtl/core_mem_bridge_pkg.sv
// core_mem_bridge_pkg: FSM state and default address window for the core/memory bridge.
package core_mem_bridge_pkg;
  typedef enum logic {BR_RUN, BR_ERR} br_state_e;
  localparam logic [31:0] DEF_ADDR_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_ADDR_SIZE = 32'h1000_0000;
endpackage

// File: rtl/bridge_rsp_track.sv
// bridge_rsp_track: outstanding counter, fixed-latency response pipe and sticky protocol error.
module bridge_rsp_track #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIXED_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic mem_rsp_valid,
  output logic can_issue,
  output logic rsp_fire,
  output logic outstanding_zero,
  output logic proto_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = FIXED_LATENCY > 0 ? FIXED_LATENCY : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pipe_q, pipe_d;
  logic proto_q, proto_d, rsp_raw;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pipe_q <= '0;
      proto_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pipe_q <= pipe_d;
      proto_q <= proto_d;
    end
  end
  // A response seen while nothing is outstanding is dropped but flagged
  always_comb begin
    rsp_raw = FIXED_LATENCY > 0 ? pipe_q[PW-1] : mem_rsp_valid;
    outstanding_zero = cnt_q == '0;
    can_issue = cnt_q < CW'(MAX_OUTSTANDING);
    rsp_fire = rsp_raw && !outstanding_zero;
    cnt_d = cnt_q + CW'(issue) - CW'(rsp_fire);
    pipe_d = (pipe_q << 1) | PW'(issue);
    proto_d = proto_q || (rsp_raw && outstanding_zero);
    proto_err = proto_q;
  end
endmodule

// File: rtl/core_mem_bridge.sv
// core_mem_bridge: core req/gnt/rvalid port to valid/ready memory channel with
// multiple outstanding transactions and local error responses for illegal addresses.
module core_mem_bridge
  import core_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIXED_LATENCY = 1,
  parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(DEF_ADDR_BASE),
  parameter logic [ADDR_W-1:0] ADDR_SIZE = ADDR_W'(DEF_ADDR_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  output logic                core_gnt,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic                core_we,
  input  logic [DATA_W/8-1:0] core_be,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write_en,
  output logic [DATA_W/8-1:0] mem_byte_en,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err,
  output logic                proto_err
);
  br_state_e state_q, state_d;
  logic legal, can_issue, rsp_fire, outstanding_zero, run;
  bridge_rsp_track #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .FIXED_LATENCY(FIXED_LATENCY)
  ) u_track (
    .clk(clk),
    .rst(rst),
    .issue(mem_valid && mem_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .can_issue(can_issue),
    .rsp_fire(rsp_fire),
    .outstanding_zero(outstanding_zero),
    .proto_err(proto_err)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BR_RUN;
    else state_q <= state_d;
  end
  // Illegal requests wait for the pipe to drain so the error response stays in order
  always_comb begin
    legal = ADDR_SIZE == '0 || (core_addr - ADDR_BASE) < ADDR_SIZE;
    state_d = (state_q == BR_RUN && core_req && !legal && outstanding_zero) ? BR_ERR : BR_RUN;
  end
  always_comb begin
    run = state_q == BR_RUN && !rst;
    mem_valid = run && core_req && legal && can_issue;
    core_gnt = run && core_req && (legal ? mem_ready && can_issue : outstanding_zero);
    core_rvalid = !rst && (state_q == BR_ERR || rsp_fire);
    core_err = !rst && (state_q == BR_ERR || (rsp_fire && mem_err));
    core_rdata = (run && rsp_fire) ? mem_rdata : '0;
    mem_addr = core_addr;
    mem_write_en = core_we;
    mem_byte_en = core_be;
    mem_wdata = core_wdata;
  end
endmodule

// File: tb/tb_core_mem_bridge.sv
// tb_core_mem_bridge: three bridge configurations (L1/MO1, L2/MO2, L0/MO2) driven by
// directed then random traffic, checked every cycle against an in-order response queue model.
module tb_core_mem_bridge;
  localparam int N = 3;
  logic clk = 0, rst = 1;
  logic req[N], gnt[N], we[N], rvalid[N], err[N], mvalid[N], mready[N], mwe[N], mrsp[N], merr[N], perr[N];
  logic [31:0] addr[N], wdata[N], rdata[N], maddr[N], mwdata[N], mrdata[N];
  logic [3:0] be[N], mbe[N];
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    core_mem_bridge #(
      .MAX_OUTSTANDING(g == 0 ? 1 : 2),
      .FIXED_LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 0))
    ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(req[g]), .core_gnt(gnt[g]), .core_addr(addr[g]), .core_we(we[g]),
      .core_be(be[g]), .core_wdata(wdata[g]), .core_rvalid(rvalid[g]), .core_rdata(rdata[g]),
      .core_err(err[g]), .mem_valid(mvalid[g]), .mem_ready(mready[g]), .mem_addr(maddr[g]),
      .mem_write_en(mwe[g]), .mem_byte_en(mbe[g]), .mem_wdata(mwdata[g]),
      .mem_rsp_valid(mrsp[g]), .mem_rdata(mrdata[g]), .mem_err(merr[g]), .proto_err(perr[g])
    );
  end

  typedef struct {
    logic [31:0] d;
    logic e;
    int due;
  } rsp_t;
  rsp_t q[N][$];
  bit errp[N], proto[N], busy[N];
  int idx[N];
  int cyc, total, bad, phase;
  bit spur;
  logic [31:0] sa[7];
  bit sw[7];

  function automatic int lat(int i);
    return i == 0 ? 1 : (i == 1 ? 2 : 0);
  endfunction
  function automatic int mo(int i);
    return i == 0 ? 1 : 2;
  endfunction
  function automatic bit legal(logic [31:0] a);
    return a >= 32'h1000_0000 && a < 32'h2000_0000;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc%0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic new_req(int i);
    be[i] = 4'($urandom);
    wdata[i] = $urandom;
    if (phase == 0) begin
      if (idx[i] < 7) begin
        busy[i] = 1;
        addr[i] = sa[idx[i]];
        we[i] = sw[idx[i]];
      end
    end else if (phase == 1 && $urandom % 5 < 3) begin
      int r;
      r = $urandom % 10;
      busy[i] = 1;
      we[i] = 1'($urandom);
      addr[i] = r == 0 ? ($urandom & 32'h0FFF_FFFC) :
                r == 1 ? 32'h2000_0000 + ($urandom % 16) * 4 :
                r == 2 ? 32'h1FFF_FFFC :
                r == 3 ? 32'hFFFF_FFFC : 32'h1000_0000 + ($urandom & 32'h0FFF_FFFC);
    end
  endtask

  task automatic drive_mem(int i);
    mrdata[i] = $urandom;
    merr[i] = 1'($urandom);
    mrsp[i] = 0;
    mready[i] = phase == 1 ? ($urandom % 4 != 0) : 1'b1;
    if (lat(i) > 0) begin
      mrsp[i] = 1'($urandom);
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        mrdata[i] = q[i][0].d;
        merr[i] = q[i][0].e;
      end
    end else if (q[i].size() > 0 && cyc >= q[i][0].due && (phase != 1 || $urandom % 3 != 0)) begin
      mrsp[i] = 1;
      mrdata[i] = q[i][0].d;
      merr[i] = q[i][0].e;
    end else if (spur) mrsp[i] = 1;
  endtask

  task automatic check_upd(int i);
    int n;
    bit lg, fire;
    logic e_gnt, e_mv, e_rv, e_er;
    logic [31:0] e_rd;
    rsp_t t;
    n = q[i].size();
    lg = legal(addr[i]);
    fire = 0;
    e_rd = 0;
    e_er = 0;
    if (errp[i]) begin
      e_gnt = 0; e_mv = 0; e_rv = 1; e_er = 1;
    end else begin
      if (n > 0) fire = lat(i) > 0 ? q[i][0].due == cyc : mrsp[i];
      e_mv = req[i] && lg && n < mo(i);
      e_gnt = lg ? e_mv && mready[i] : req[i] && n == 0;
      e_rv = fire;
      if (fire) begin
        e_rd = q[i][0].d;
        e_er = q[i][0].e;
      end
    end
    chk("gnt", i, gnt[i], e_gnt);
    chk("mem_valid", i, mvalid[i], e_mv);
    chk("rvalid", i, rvalid[i], e_rv);
    chk("rdata", i, rdata[i], e_rd);
    chk("err", i, err[i], e_er);
    chk("proto_err", i, perr[i], proto[i]);
    if (e_mv) begin
      chk("mem_addr", i, maddr[i], addr[i]);
      chk("mem_we_be", i, {mwe[i], mbe[i]}, {we[i], be[i]});
      chk("mem_wdata", i, mwdata[i], wdata[i]);
    end
    if (fire) void'(q[i].pop_front());
    if (e_gnt && lg) begin
      t.d = (phase == 0 && addr[i] == 32'h1000_0000) ? 32'hDEADBEEF : $urandom;
      t.e = phase == 0 ? (we[i] && addr[i] == 32'h1000_0008) : ($urandom % 6 == 0);
      t.due = lat(i) > 0 ? cyc + lat(i) :
              cyc + (phase == 0 ? (idx[i] == 1 ? 5 : 2) : int'($urandom_range(1, 4)));
      q[i].push_back(t);
    end
    if (lat(i) == 0 && mrsp[i] && n == 0) proto[i] = 1;
    if (e_gnt) begin
      busy[i] = 0;
      if (phase == 0) idx[i]++;
    end
    errp[i] = e_gnt && !lg;
  endtask

  task automatic lits();
    if (phase == 0) begin
      if (cyc == 0) chk("L1 first gnt", 0, gnt[0], 1);
      if (cyc == 1) begin
        chk("L1 no second gnt", 0, gnt[0], 0);
        chk("L1 rvalid", 0, rvalid[0], 1);
        chk("L1 rdata", 0, rdata[0], 32'hDEADBEEF);
        chk("L2 b2b gnt", 1, gnt[1], 1);
      end
      if (cyc == 2) begin
        chk("L2 rvalid first", 1, rvalid[1], 1);
        chk("L2 rdata first", 1, rdata[1], 32'hDEADBEEF);
        chk("L2 stall at MO", 1, gnt[1], 0);
        chk("L0 stall at MO", 2, gnt[2], 0);
        chk("L0 rvalid", 2, rvalid[2], 1);
        chk("L0 rdata", 2, rdata[2], 32'hDEADBEEF);
      end
      if (cyc == 3) begin
        chk("L2 rvalid second", 1, rvalid[1], 1);
        chk("L0 gnt after drop", 2, gnt[2], 1);
      end
      if (cyc == 6) begin
        chk("illegal gnt", 0, gnt[0], 1);
        chk("illegal no mem_valid", 0, mvalid[0], 0);
      end
      if (cyc == 7) begin
        chk("err rsp rvalid", 0, rvalid[0], 1);
        chk("err rsp err", 0, err[0], 1);
        chk("err rsp rdata", 0, rdata[0], 0);
      end
      if (cyc == 9) begin
        chk("write memerr rvalid", 0, rvalid[0], 1);
        chk("write memerr err", 0, err[0], 1);
      end
      if (cyc == 10) chk("boundary illegal gnt", 0, gnt[0], 1);
    end
    if (phase == 3) chk("spurious no rvalid", 2, rvalid[2], 0);
  endtask

  task automatic step();
    for (int i = 0; i < N; i++) begin
      if (!busy[i]) new_req(i);
      req[i] = busy[i];
      drive_mem(i);
    end
    #1;
    for (int i = 0; i < N; i++) check_upd(i);
    lits();
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_zero(string nm);
    for (int i = 0; i < N; i++) begin
      chk({nm, " gnt"}, i, gnt[i], 0);
      chk({nm, " rvalid"}, i, rvalid[i], 0);
      chk({nm, " err"}, i, err[i], 0);
      chk({nm, " rdata"}, i, rdata[i], 0);
      chk({nm, " mem_valid"}, i, mvalid[i], 0);
      chk({nm, " proto"}, i, perr[i], 0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      errp[i] = 0;
      proto[i] = 0;
      busy[i] = 0;
    end
  endtask

  initial begin
    int k;
    sa = '{32'h1000_0000, 32'h1000_0004, 32'h1000_000C, 32'h0000_0100,
           32'h1000_0008, 32'h2000_0000, 32'h1FFF_FFFC};
    sw = '{0, 0, 0, 0, 1, 0, 0};
    total = 0; bad = 0; cyc = 0; spur = 0; phase = 0;
    clear_model();
    for (int i = 0; i < N; i++) begin
      idx[i] = 0;
      req[i] = 1; addr[i] = 32'h1000_0000; we[i] = 0; be[i] = 4'hF; wdata[i] = 0;
      mready[i] = 1; mrsp[i] = 1; mrdata[i] = 32'hFFFF_FFFF; merr[i] = 1;
    end
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 0;
    repeat (20) step();
    phase = 1;
    repeat (3000) step();
    phase = 2;
    repeat (15) step();
    k = 0;
    while ((q[2].size() != 0 || busy[2] || errp[2]) && k < 50) begin
      step();
      k++;
    end
    chk("drain before spurious", 2, k < 50, 1);
    phase = 3;
    spur = 1;
    step();
    spur = 0;
    phase = 2;
    #1 chk("proto set", 2, perr[2], 1);
    phase = 1;
    repeat (6) step();
    chk("proto sticky", 2, perr[2], 1);
    rst = 1;
    #1 check_zero("mid reset");
    clear_model();
    @(negedge clk);
    rst = 0;
    repeat (300) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
